timer_mmio_ctrl: RTL and testbench
==================================

# timer_mmio_ctrl

Memory-mapped control front end for the `digitalTimer` block. It sits directly upstream of the timer on the core's peripheral bus. It turns register writes into `timer_set_val`/`set_timer` arm pulses, watches `timer_is_high` for expiry, and latches it into a sticky pending bit that drives a level interrupt. Optional auto-reload re-arms the timer for periodic interrupts.

## Interface
- `ADDR_W`, 4: bus byte-address width; bits [1:0] ignored (word access only).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `bus_req`  in  1  access request, one cycle per access.
- `bus_we`  in  1  1 = write, 0 = read; sampled with `bus_req`.
- `bus_addr`  in  ADDR_W  byte address.
- `bus_wdata`  in  32  write data.
- `bus_ready`  out  1  access complete, one cycle after `bus_req`.
- `bus_rdata`  out  32  read data, valid while `bus_ready`=1, else 0.
- `timer_set_val`  out  32  arm value to `digitalTimer`.
- `set_timer`  out  1  one-cycle arm pulse to `digitalTimer`.
- `timer_is_high`  in  1  expiry level from `digitalTimer`.
- `irq`  out  1  interrupt request = `STATUS.pending & CTRL.irq_en`.

## Operation
- Registers:
  - 0x0 CTRL: bit0 `enable`, bit1 `periodic`, bit2 `irq_en`; other bits read 0.
  - 0x4 LOAD: 32-bit arm value.
  - 0x8 STATUS: bit0 `pending` (write-1-to-clear), bit1 `running` (RO, 1 in ARM/RUN/EXPIRE).
  - 0xC: reads 0. Unmapped writes are ignored.
- FSM states: IDLE, ARM, RUN, EXPIRE.
  - IDLE: a CTRL write with `enable`=1 and LOAD≠0 goes to ARM. If LOAD=0, the `enable` bit is not set.
  - ARM: `set_timer`=1 for exactly one cycle, `timer_set_val`=LOAD; go to RUN.
  - RUN: `timer_is_high`=1 goes to EXPIRE. A CTRL write with `enable`=0 goes to IDLE; pending is not set.
  - EXPIRE: set `pending`. If `periodic` and `enable`, go to ARM. Otherwise clear `enable` and go to IDLE.
- `timer_set_val` holds the last armed value between pulses.
- A LOAD write while running takes effect at the next ARM.
- Simultaneous EXPIRE set and W1C clear of `pending`: set wins.
- `timer_is_high` is ignored in IDLE, ARM, and EXPIRE.

## Timing
- Reset values: all registers 0, state IDLE, `bus_ready`=0, `bus_rdata`=0, `set_timer`=0, `timer_set_val`=0, `irq`=0.
- Bus:
  - Every access gets `bus_ready`=1 exactly one cycle after `bus_req`.
  - Write effects are visible from the `bus_ready` cycle.
  - Back-to-back requests are legal; there are no wait states.
- An enabling CTRL write in cycle t gives `set_timer`=1 in cycle t+1.
- Expiry: `timer_is_high` sampled 1 in cycle t gives `pending`=1 and `irq` (if enabled) in cycle t+1.
- Periodic mode: consecutive `set_timer` pulses are LOAD+2 cycles apart.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous). No pulse is emitted on reset release.

## Configuration
- `TIMER_PERIODIC_EN` defined: CTRL.`periodic` is read/write and auto-reload works as above.
- Not defined: `periodic` reads 0 and writes are ignored. Every expiry returns to IDLE with `enable` cleared (one-shot only).

## Structure
- Shared package `timer_pkg` holds:
  - register offsets (`TIMER_CTRL_OFS`, `TIMER_LOAD_OFS`, `TIMER_STATUS_OFS`);
  - CTRL/STATUS bit indices;
  - FSM enum `timer_ctrl_state_e`.
- No sub-module. Register file and FSM live in one module. `digitalTimer` is instantiated beside it in the parent.

## Test plan
- Reset, then read all three registers -> all read 0; `irq`=0; `set_timer` never pulsed.
- Write LOAD=5, then CTRL=0x5 -> one `set_timer` pulse with `timer_set_val`=5. `pending`=1 and `irq`=1 one cycle after `timer_is_high` rises. CTRL reads 0x4 after expiry.
- CTRL=0x7, LOAD=3 with `TIMER_PERIODIC_EN` -> `set_timer` pulses every 5 cycles. Write STATUS=0x1 -> `pending` clears, then re-sets at the next expiry.
- Write CTRL=0x0 while RUN -> FSM goes to IDLE. A later `timer_is_high`=1 leaves `pending`=0.
- LOAD=0, CTRL=0x1 -> CTRL reads 0 and no `set_timer` pulse.
- Pulse `rst` low during RUN with `pending`=1 -> all outputs 0 at once; no pulse after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer MMIO control front end: register map,
// CTRL/STATUS bit positions, FSM encoding and register-image helpers.
package timer_pkg;

    localparam logic [3:0] TIMER_CTRL_OFS   = 4'h0;
    localparam logic [3:0] TIMER_LOAD_OFS   = 4'h4;
    localparam logic [3:0] TIMER_STATUS_OFS = 4'h8;

    localparam int unsigned CTRL_ENABLE_BIT    = 0;
    localparam int unsigned CTRL_PERIODIC_BIT  = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT    = 2;
    localparam int unsigned STATUS_PENDING_BIT = 0;
    localparam int unsigned STATUS_RUNNING_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_RUN    = 2'd2,
        ST_EXPIRE = 2'd3
    } timer_ctrl_state_e;

    // Assemble the CTRL read image; unused bits read as zero.
    function automatic logic [31:0] ctrl_word(input logic enable,
                                              input logic periodic,
                                              input logic irq_en);
        logic [31:0] w;
        w                    = 32'd0;
        w[CTRL_ENABLE_BIT]   = enable;
        w[CTRL_PERIODIC_BIT] = periodic;
        w[CTRL_IRQ_EN_BIT]   = irq_en;
        return w;
    endfunction

    // Assemble the STATUS read image; unused bits read as zero.
    function automatic logic [31:0] status_word(input logic pending,
                                                input logic running);
        logic [31:0] w;
        w                     = 32'd0;
        w[STATUS_PENDING_BIT] = pending;
        w[STATUS_RUNNING_BIT] = running;
        return w;
    endfunction

endpackage

// File: rtl/timer_mmio_ctrl.sv
// Register file and arm/expire FSM in front of digitalTimer.
// Optional auto-reload is compiled in with `define TIMER_PERIODIC_EN.
module timer_mmio_ctrl
    import timer_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_ready,
    output logic [31:0]       bus_rdata,
    output logic [31:0]       timer_set_val,
    output logic              set_timer,
    input  logic              timer_is_high,
    output logic              irq
);

    timer_ctrl_state_e state_r;
    timer_ctrl_state_e state_nxt_s;

    logic        enable_r;
    logic        periodic_r;
    logic        irq_en_r;
    logic        pending_r;
    logic [31:0] load_r;

    logic        enable_req_s;
    logic        enable_nxt_s;
    logic        periodic_nxt_s;
    logic        irq_en_nxt_s;
    logic        pending_nxt_s;
    logic [31:0] load_nxt_s;
    logic        set_pend_s;

    logic        bus_ready_r;
    logic [31:0] bus_rdata_r;
    logic        set_timer_r;
    logic [31:0] timer_set_val_r;
    logic        irq_r;

    logic [ADDR_W-1:0] addr_word_s;
    logic              ctrl_sel_s;
    logic              load_sel_s;
    logic              status_sel_s;
    logic              ctrl_wr_s;
    logic              load_wr_s;
    logic              status_wr_s;
    logic              rd_s;
    logic              running_s;
    logic              arm_s;
    logic [31:0]       rdata_mux_s;

    // Word-aligned address decode; the two byte-lane bits are masked off.
    assign addr_word_s  = bus_addr & ~ADDR_W'(2'b11);
    assign ctrl_sel_s   = (addr_word_s == ADDR_W'(TIMER_CTRL_OFS));
    assign load_sel_s   = (addr_word_s == ADDR_W'(TIMER_LOAD_OFS));
    assign status_sel_s = (addr_word_s == ADDR_W'(TIMER_STATUS_OFS));
    assign ctrl_wr_s    = bus_req & bus_we & ctrl_sel_s;
    assign load_wr_s    = bus_req & bus_we & load_sel_s;
    assign status_wr_s  = bus_req & bus_we & status_sel_s;
    assign rd_s         = bus_req & ~bus_we;
    assign running_s    = (state_r != ST_IDLE);
    assign enable_req_s = ctrl_wr_s ? bus_wdata[CTRL_ENABLE_BIT] : enable_r;

    // Next values of the software-visible configuration fields.
    always_comb begin
        load_nxt_s     = load_r;
        irq_en_nxt_s   = irq_en_r;
        periodic_nxt_s = periodic_r;
        if (load_wr_s) begin
            load_nxt_s = bus_wdata;
        end else begin
            load_nxt_s = load_r;
        end
        if (ctrl_wr_s) begin
            irq_en_nxt_s = bus_wdata[CTRL_IRQ_EN_BIT];
`ifdef TIMER_PERIODIC_EN
            periodic_nxt_s = bus_wdata[CTRL_PERIODIC_BIT];
`else
            periodic_nxt_s = 1'b0;
`endif
        end else begin
            irq_en_nxt_s   = irq_en_r;
            periodic_nxt_s = periodic_r;
        end
    end

    // Arm/run/expire sequencing; enable is owned here since the FSM may clear it.
    always_comb begin
        state_nxt_s  = state_r;
        enable_nxt_s = enable_req_s;
        set_pend_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A zero reload value would never expire, so refuse to enable.
                if (ctrl_wr_s && bus_wdata[CTRL_ENABLE_BIT] && (load_r != 32'd0)) begin
                    state_nxt_s  = ST_ARM;
                    enable_nxt_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_IDLE;
                    enable_nxt_s = 1'b0;
                end
            end
            ST_ARM: begin
                if (enable_req_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Disable beats a coincident expiry: no pending for a cancelled run.
                if (!enable_req_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (timer_is_high) begin
                    state_nxt_s = ST_EXPIRE;
                    set_pend_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_EXPIRE: begin
                if (enable_req_s && periodic_nxt_s && (load_r != 32'd0)) begin
                    state_nxt_s  = ST_ARM;
                    enable_nxt_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_IDLE;
                    enable_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                enable_nxt_s = 1'b0;
            end
        endcase
    end

    // Sticky pending flag: expiry set has priority over the write-1 clear.
    always_comb begin
        pending_nxt_s = pending_r;
        if (set_pend_s) begin
            pending_nxt_s = 1'b1;
        end else if (status_wr_s && bus_wdata[STATUS_PENDING_BIT]) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Read data multiplexer; unmapped words read zero.
    always_comb begin
        rdata_mux_s = 32'd0;
        case (1'b1)
            ctrl_sel_s:   rdata_mux_s = ctrl_word(enable_r, periodic_r, irq_en_r);
            load_sel_s:   rdata_mux_s = load_r;
            status_sel_s: rdata_mux_s = status_word(pending_r, running_s);
            default:      rdata_mux_s = 32'd0;
        endcase
    end

    assign arm_s = (state_nxt_s == ST_ARM);

    // State and register storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            enable_r   <= 1'b0;
            periodic_r <= 1'b0;
            irq_en_r   <= 1'b0;
            pending_r  <= 1'b0;
            load_r     <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            enable_r   <= enable_nxt_s;
            periodic_r <= periodic_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            pending_r  <= pending_nxt_s;
            load_r     <= load_nxt_s;
        end
    end

    // Registered outputs; irq and set_timer are computed from next-state so
    // they line up with the cycle in which the underlying state becomes visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_ready_r     <= 1'b0;
            bus_rdata_r     <= 32'd0;
            set_timer_r     <= 1'b0;
            timer_set_val_r <= 32'd0;
            irq_r           <= 1'b0;
        end else begin
            bus_ready_r     <= bus_req;
            bus_rdata_r     <= rd_s ? rdata_mux_s : 32'd0;
            set_timer_r     <= arm_s;
            timer_set_val_r <= arm_s ? load_r : timer_set_val_r;
            irq_r           <= pending_nxt_s & irq_en_nxt_s;
        end
    end

    assign bus_ready     = bus_ready_r;
    assign bus_rdata     = bus_rdata_r;
    assign set_timer     = set_timer_r;
    assign timer_set_val = timer_set_val_r;
    assign irq           = irq_r;

endmodule

// File: tb/tb_timer_mmio_ctrl.sv
// Scoreboard bench for timer_mmio_ctrl with a behavioural digitalTimer model.
module tb_timer_mmio_ctrl;

    logic        clk;
    logic        rst;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [31:0] timer_set_val;
    logic        set_timer;
    logic        timer_is_high;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] rd_exp_q[$];
    logic [31:0] pulse_exp_q[$];
    int          pulse_times[$];
    logic        req_seen;
    logic        set_prev;
    logic [31:0] tm_cnt;
    logic        tm_active;

    timer_mmio_ctrl #(.ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .timer_set_val(timer_set_val),
        .set_timer    (set_timer),
        .timer_is_high(timer_is_high),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // digitalTimer model: expires LOAD cycles after the arm pulse, level held until re-armed.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tm_cnt    <= 32'd0;
            tm_active <= 1'b0;
        end else if (set_timer) begin
            tm_cnt    <= timer_set_val;
            tm_active <= 1'b1;
        end else if (tm_active && tm_cnt > 32'd1) begin
            tm_cnt <= tm_cnt - 32'd1;
        end
    end
    assign timer_is_high = tm_active && (tm_cnt == 32'd1);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_seen <= 1'b0;
            set_prev <= 1'b0;
        end else begin
            req_seen <= bus_req;
            set_prev <= set_timer;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor: pops expected read data and arm values as the DUT produces them.
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_latency", 32'(bus_ready), 32'(req_seen));
            if (bus_ready) begin
                if (rd_exp_q.size() == 0) chk("ready_unexpected", 32'd1, 32'd0);
                else chk("bus_rdata", bus_rdata, rd_exp_q.pop_front());
            end else begin
                chk("rdata_idle", bus_rdata, 32'd0);
            end
            if (set_timer) begin
                pulse_times.push_back(cyc);
                chk("pulse_width", 32'(set_prev), 32'd0);
                if (pulse_exp_q.size() == 0) chk("pulse_unexpected", 32'd1, 32'd0);
                else chk("timer_set_val", timer_set_val, pulse_exp_q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        rd_exp_q.push_back(32'd0);
        @(negedge clk);
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = a;
        rd_exp_q.push_back(exp);
        @(negedge clk);
        bus_req  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_high(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (timer_is_high) break;
        end
        if (k == budget) chk("timer_high_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_irq(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (irq) break;
        end
        if (k == budget) chk("irq_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (pulse_times.size() >= n) break;
        end
        if (k == budget) chk("pulse_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 4'h0;
        bus_wdata = 32'd0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus_ready), 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        chk("rst_set_timer", 32'(set_timer), 32'd0);
        chk("rst_set_val", timer_set_val, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b1;
        idle(2);
        bus_read(4'h0, 32'd0);
        bus_read(4'h4, 32'd0);
        bus_read(4'h8, 32'd0);
        bus_read(4'hC, 32'd0);
        chk("irq_after_reset", 32'(irq), 32'd0);

        // One-shot with irq; W1C coincident with expiry must lose to the set
        bus_write(4'h4, 32'd5);
        pulse_exp_q.push_back(32'd5);
        bus_write(4'h0, 32'h5);
        chk("arm_latency", 32'(set_timer), 32'd1);
        wait_high(20);
        chk("irq_before_expire", 32'(irq), 32'd0);
        bus_write(4'h8, 32'h1);
        chk("irq_after_expire", 32'(irq), 32'd1);
        idle(3);
        bus_read(4'h8, 32'h1);
        bus_read(4'h0, 32'h4);
        bus_write(4'h8, 32'h1);
        chk("irq_after_w1c", 32'(irq), 32'd0);
        bus_read(4'h8, 32'h0);

        // Periodic reload (one-shot fallback when the feature is compiled out)
        pulse_times.delete();
        bus_write(4'h4, 32'd3);
`ifdef TIMER_PERIODIC_EN
        repeat (3) pulse_exp_q.push_back(32'd3);
        bus_write(4'h0, 32'h7);
        wait_irq(20);
        bus_write(4'h8, 32'h1);
        chk("periodic_w1c", 32'(irq), 32'd0);
        wait_irq(20);
        chk("periodic_repend", 32'(irq), 32'd1);
        wait_pulses(3, 20);
        bus_write(4'h0, 32'h4);
        if (pulse_times.size() >= 3) begin
            chk("period_gap0", 32'(pulse_times[1] - pulse_times[0]), 32'd5);
            chk("period_gap1", 32'(pulse_times[2] - pulse_times[1]), 32'd5);
        end else begin
            chk("period_pulse_count", 32'(pulse_times.size()), 32'd3);
        end
        idle(8);
`else
        pulse_exp_q.push_back(32'd3);
        bus_write(4'h0, 32'h7);
        bus_read(4'h0, 32'h5);
        wait_irq(20);
        idle(12);
        bus_read(4'h0, 32'h4);
        chk("oneshot_pulse_count", 32'(pulse_times.size()), 32'd1);
`endif
        bus_write(4'h8, 32'h1);
        bus_read(4'h8, 32'h0);

        // Disable while running: later expiry must not set pending
        bus_write(4'h4, 32'd10);
        pulse_exp_q.push_back(32'd10);
        bus_write(4'h0, 32'h5);
        idle(2);
        bus_write(4'h0, 32'h4);
        bus_read(4'h8, 32'h0);
        wait_high(30);
        idle(2);
        bus_read(4'h8, 32'h0);
        chk("irq_after_cancel", 32'(irq), 32'd0);

        // LOAD=0 refuses to enable
        bus_write(4'h4, 32'd0);
        bus_write(4'h0, 32'h1);
        chk("zero_load_no_arm", 32'(set_timer), 32'd0);
        bus_read(4'h0, 32'h0);
        idle(10);

        // Asynchronous reset during RUN with pending set
        bus_write(4'h4, 32'd2);
        pulse_exp_q.push_back(32'd2);
        bus_write(4'h0, 32'h5);
        wait_irq(20);
        idle(2);
        bus_write(4'h4, 32'd20);
        pulse_exp_q.push_back(32'd20);
        bus_write(4'h0, 32'h5);
        idle(3);
        chk("irq_pending_in_run", 32'(irq), 32'd1);
        bus_read(4'h8, 32'h3);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_set_val", timer_set_val, 32'd0);
        chk("async_rst_set_timer", 32'(set_timer), 32'd0);
        chk("async_rst_ready", 32'(bus_ready), 32'd0);
        chk("async_rst_rdata", bus_rdata, 32'd0);
        rd_exp_q.delete();
        pulse_exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        idle(30);
        chk("irq_after_release", 32'(irq), 32'd0);
        bus_read(4'h8, 32'h0);
        bus_read(4'h0, 32'h0);
        bus_read(4'h4, 32'h0);
        idle(2);
        chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        chk("pulse_queue_drained", 32'(pulse_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
